// File: rtl/iteration_reader_if.sv
// Bundle of the signals between the iteration reader and the blocks around it:
// the scan control/status pins, the grid-memory read port and the neighbourhood
// stream towards the rule engine.
//
// Handshake: cell_valid/cell_ready follow strict valid/ready rules. Once
// cell_valid rises, it and the payload (neighbourhood, cell_x, cell_y) stay
// stable until a rising edge on which cell_valid and cell_ready are both high.
// That edge is the transfer. cell_ready may change freely and never feeds back
// into cell_valid. The read port has no ready signal: rd_data is returned
// exactly one cycle after rd_en, and rd_en stays low while framebuffer_mutex
// is high.
interface iteration_reader_if;
  logic        start;
  logic        busy;
  logic        finished;
  logic        rd_en;
  logic [11:0] rd_x;
  logic [11:0] rd_y;
  logic        rd_data;
  logic        framebuffer_mutex;
  logic        cell_valid;
  logic        cell_ready;
  logic [8:0]  neighbourhood;
  logic [11:0] cell_x;
  logic [11:0] cell_y;

  // The reader's own view of the bundle.
  modport master (
    input  start, rd_data, framebuffer_mutex, cell_ready,
    output busy, finished, rd_en, rd_x, rd_y,
    output cell_valid, neighbourhood, cell_x, cell_y
  );

  // The view of the surroundings: controller, grid memory and rule engine.
  modport slave (
    output start, rd_data, framebuffer_mutex, cell_ready,
    input  busy, finished, rd_en, rd_x, rd_y,
    input  cell_valid, neighbourhood, cell_x, cell_y
  );
endinterface

// File: rtl/iteration_reader.sv
// Iteration reader: walks the grid in raster order. For each cell it fetches
// the 3x3 neighbourhood from the 1-bit grid memory, one neighbour per cycle,
// and then presents it to the rule engine over a valid/ready handshake.
// Neighbours outside the grid read as dead. The grid does not wrap around.
module iteration_reader #(
  parameter int GRID_W = 64,
  parameter int GRID_H = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  iteration_reader_if.master bus,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [11:0] X_LAST = 12'(GRID_W - 1);
  localparam logic [11:0] Y_LAST = 12'(GRID_H - 1);

  state_t      state;
  logic [11:0] x_q;
  logic [11:0] y_q;
  logic [1:0]  kcol;       // dx + 1 of the neighbour being fetched
  logic [1:0]  krow;       // dy + 1 of the neighbour being fetched
  logic [8:0]  nbh_q;
  logic        busy_q;
  logic        finished_q;
  logic        valid_q;
  logic        pend_q;     // a read was issued last cycle, so rd_data is live now
  logic [3:0]  pend_k;     // neighbour index that the live rd_data belongs to

  logic [3:0]  k_idx;
  logic [11:0] nx;
  logic [11:0] ny;
  logic        in_grid;
  logic        last_k;
  logic        last_cell;
  logic        fetch_go;
  logic        hs;

  // Neighbour index, neighbour address and border test for the current fetch.
  // The border test compares the centre against the grid edges directly, so
  // the wrapped value of nx/ny at coordinate 0 is never trusted.
  always_comb begin
    k_idx     = ({2'b00, krow} * 4'd3) + {2'b00, kcol};
    nx        = x_q + {10'b0, kcol} - 12'd1;
    ny        = y_q + {10'b0, krow} - 12'd1;
    in_grid   = !((kcol == 2'd0 && x_q == 12'd0)  ||
                  (kcol == 2'd2 && x_q == X_LAST) ||
                  (krow == 2'd0 && y_q == 12'd0)  ||
                  (krow == 2'd2 && y_q == Y_LAST));
    last_k    = (kcol == 2'd2) && (krow == 2'd2);
    last_cell = (x_q == X_LAST) && (y_q == Y_LAST);
    fetch_go  = (state == S_FETCH) && (!in_grid || !bus.framebuffer_mutex);
    hs        = valid_q && bus.cell_ready;
  end

  // The read strobe has to react to framebuffer_mutex in the same cycle, so
  // it is decoded from registered state rather than registered itself. The
  // address is zero whenever no read is issued.
  assign bus.rd_en = (state == S_FETCH) && in_grid && !bus.framebuffer_mutex;
  assign bus.rd_x  = bus.rd_en ? nx : 12'd0;
  assign bus.rd_y  = bus.rd_en ? ny : 12'd0;

  assign bus.busy          = busy_q;
  assign bus.finished      = finished_q;
  assign bus.cell_valid    = valid_q;
  assign bus.neighbourhood = nbh_q;
  assign bus.cell_x        = x_q;
  assign bus.cell_y        = y_q;
  assign dbg_state         = state;

  // Scan FSM: coordinate and neighbour counters, read-data capture and the
  // registered status/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      x_q        <= 12'd0;
      y_q        <= 12'd0;
      kcol       <= 2'd0;
      krow       <= 2'd0;
      nbh_q      <= 9'd0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_k     <= 4'd0;
    end else begin
      pend_q <= bus.rd_en;
      pend_k <= k_idx;
      // Capture is keyed only on last cycle's strobe. The mutex level in the
      // capture cycle does not matter.
      if (pend_q) nbh_q[pend_k] <= bus.rd_data;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            x_q    <= 12'd0;
            y_q    <= 12'd0;
            kcol   <= 2'd0;
            krow   <= 2'd0;
            nbh_q  <= 9'd0;
            busy_q <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (fetch_go) begin
            if (last_k) begin
              state <= S_WAIT;
            end else if (kcol == 2'd2) begin
              kcol <= 2'd0;
              krow <= krow + 2'd1;
            end else begin
              kcol <= kcol + 2'd1;
            end
          end
        end
        S_WAIT: begin
          valid_q <= 1'b1;
          state   <= S_PRESENT;
        end
        S_PRESENT: begin
          if (hs) begin
            valid_q <= 1'b0;
            if (last_cell) begin
              finished_q <= 1'b1;
              state      <= S_DONE;
            end else begin
              if (x_q == X_LAST) begin
                x_q <= 12'd0;
                y_q <= y_q + 12'd1;
              end else begin
                x_q <= x_q + 12'd1;
              end
              kcol  <= 2'd0;
              krow  <= 2'd0;
              nbh_q <= 9'd0;
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          finished_q <= 1'b0;
          busy_q     <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iteration_reader.sv
// Bench for iteration_reader on a 4x3 grid. A grid-memory model answers reads
// and returns noise when no read is pending. The scoreboard holds the expected
// cells and the expected read addresses. Both come from a direct neighbourhood
// computation over the memory contents.
module tb_iteration_reader;
  localparam int GW   = 4;
  localparam int GH   = 3;
  localparam int MAXC = 1024;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  iteration_reader_if bus ();
  logic [2:0] dbg_state;

  iteration_reader #(.GRID_W(GW), .GRID_H(GH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- grid memory model ----------------
  logic mem [GH][GW];
  always @(posedge clk) begin
    if (bus.rd_en && bus.rd_x < GW && bus.rd_y < GH)
      bus.rd_data <= mem[int'(bus.rd_y)][int'(bus.rd_x)];
    else
      bus.rd_data <= 1'($urandom_range(0, 1));
  end

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_bad = 0;
  logic [32:0] exp_q[$];      // {y, x, neighbourhood}
  logic [23:0] exp_rd_q[$];   // {y, x} of each expected read
  int          hs_rel[$];
  int          fin_rel[$];
  int          rd_cnt;
  int          exp_reads;
  int          edge_n = 0;
  int          t0 = 0;
  logic [8:0]  got_nbh [GH][GW];
  bit          mutex_at    [MAXC];
  bit          ready_lo_at [MAXC];
  bit          start_at    [MAXC];

  typedef struct {
    int         pat;
    int         x;
    int         y;
    logic [8:0] nbh;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: samples in mid-cycle. Relative cycle number is edge_n + 1 - t0.
  logic        prev_stall = 1'b0;
  logic [32:0] prev_snap;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.start && !bus.busy) t0 = edge_n + 1;
      if (bus.rd_en) begin
        rd_cnt++;
        check("rd_en_under_mutex", 64'(bus.framebuffer_mutex), 64'd0);
        check("rd_en_outside_fetch", {61'd0, bus.cell_valid, bus.finished, !bus.busy}, 64'd0);
        check("rd_addr_in_grid", 64'(bus.rd_x < GW && bus.rd_y < GH), 64'd1);
        if (exp_rd_q.size() == 0) check("rd_unexpected", 64'(bus.rd_en), 64'd0);
        else check("rd_order", {40'd0, bus.rd_y, bus.rd_x}, 64'(exp_rd_q.pop_front()));
      end
      if (prev_stall) begin
        check("stall_valid", 64'(bus.cell_valid), 64'd1);
        check("stall_hold", 64'({bus.cell_y, bus.cell_x, bus.neighbourhood}), 64'(prev_snap));
      end
      prev_stall = bus.cell_valid && !bus.cell_ready;
      prev_snap  = {bus.cell_y, bus.cell_x, bus.neighbourhood};
      if (bus.cell_valid && bus.cell_ready) begin
        hs_rel.push_back(edge_n + 1 - t0);
        if (bus.cell_x < GW && bus.cell_y < GH)
          got_nbh[int'(bus.cell_y)][int'(bus.cell_x)] = bus.neighbourhood;
        if (exp_q.size() == 0) check("cell_unexpected", 64'(bus.cell_valid), 64'd0);
        else check("cell", 64'({bus.cell_y, bus.cell_x, bus.neighbourhood}), 64'(exp_q.pop_front()));
      end
      if (bus.finished) fin_rel.push_back(edge_n + 1 - t0);
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // Dead border, no wrap-around: neighbours outside the grid are 0 and are not read.
  task automatic build_model();
    exp_q.delete();
    exp_rd_q.delete();
    exp_reads = 0;
    for (int y = 0; y < GH; y++) begin
      for (int x = 0; x < GW; x++) begin
        logic [8:0] n;
        n = '0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int cx, cy;
            cx = x + dx;
            cy = y + dy;
            if (cx >= 0 && cx < GW && cy >= 0 && cy < GH) begin
              n[(dy + 1) * 3 + dx + 1] = mem[cy][cx];
              exp_rd_q.push_back({12'(cy), 12'(cx)});
              exp_reads++;
            end
          end
        end
        exp_q.push_back({12'(y), 12'(x), n});
      end
    end
  endtask

  // 0: only (1,1) live, 1: all live, 2: random.
  task automatic set_mem(input int mode);
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++)
        mem[y][x] = (mode == 1) ? 1'b1 :
                    (mode == 0) ? 1'((x == 1) && (y == 1)) : 1'($urandom_range(0, 1));
  endtask

  task automatic clear_sched();
    for (int c = 0; c < MAXC; c++) begin
      mutex_at[c]    = 1'b0;
      ready_lo_at[c] = 1'b0;
      start_at[c]    = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start from IDLE and play the per-cycle schedules until finished.
  task automatic run_scan(input int max_cyc);
    int c;
    hs_rel.delete();
    fin_rel.delete();
    rd_cnt    = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    c = 1;
    while (fin_rel.size() == 0 && c < max_cyc) begin
      bus.framebuffer_mutex = mutex_at[c];
      bus.cell_ready        = !ready_lo_at[c];
      bus.start             = start_at[c];
      tick();
      c++;
    end
    bus.framebuffer_mutex = 1'b0;
    bus.cell_ready        = 1'b1;
    bus.start             = 1'b0;
    if (fin_rel.size() == 0)
      $display("FAIL scan_timeout: no finished after %0d cycles (state %0d)", c, dbg_state);
    repeat (3) tick();
    check("finished_once", 64'(fin_rel.size()), 64'd1);
    check("busy_after_scan", 64'(bus.busy), 64'd0);
    check("rd_count", 64'(rd_cnt), 64'(exp_reads));
    check("cells_left", 64'(exp_q.size()), 64'd0);
    check("reads_left", 64'(exp_rd_q.size()), 64'd0);
  endtask

  // Expected handshake N at 11 + 11N, pushed back by stalls at or before cell N.
  task automatic check_timing(input int bp_cell, input int bp_len, input int mx_cell, input int mx_len);
    check("hs_count", 64'(hs_rel.size()), 64'(GW * GH));
    for (int n = 0; n < hs_rel.size() && n < GW * GH; n++)
      check("hs_cycle", 64'(hs_rel[n]),
            64'(11 + 11 * n + ((n >= bp_cell) ? bp_len : 0) + ((n >= mx_cell) ? mx_len : 0)));
    if (fin_rel.size() > 0)
      check("finished_cycle", 64'(fin_rel[0]), 64'(133 + bp_len + mx_len));
  endtask

  task automatic check_table(input int pat);
    for (int i = 0; i < 10; i++)
      if (tbl[i].pat == pat)
        check($sformatf("tbl_p%0d_(%0d,%0d)", pat, tbl[i].x, tbl[i].y),
              64'(got_nbh[tbl[i].y][tbl[i].x]), 64'(tbl[i].nbh));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{0, 0, 0, 9'h100};
    tbl[1] = '{0, 1, 1, 9'h010};
    tbl[2] = '{0, 2, 2, 9'h001};
    tbl[3] = '{0, 3, 0, 9'h000};
    tbl[4] = '{0, 3, 1, 9'h000};
    tbl[5] = '{0, 3, 2, 9'h000};
    tbl[6] = '{0, 1, 0, 9'h080};
    tbl[7] = '{1, 0, 0, 9'h1B0};
    tbl[8] = '{1, 3, 2, 9'h01B};
    tbl[9] = '{1, 1, 1, 9'h1FF};

    bus.start             = 1'b0;
    bus.framebuffer_mutex = 1'b0;
    bus.cell_ready        = 1'b1;
    clear_sched();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({bus.busy, bus.finished, bus.rd_en, bus.rd_x, bus.rd_y,
                                bus.cell_valid, bus.neighbourhood, bus.cell_x, bus.cell_y}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single live cell, baseline timing
    set_mem(0);
    build_model();
    run_scan(400);
    check_table(0);
    check_timing(99, 0, 99, 0);
    check("rd_count_4x3", 64'(rd_cnt), 64'd70);

    // All-ones memory, border masking
    set_mem(1);
    build_model();
    run_scan(400);
    check_table(1);
    check_timing(99, 0, 99, 0);

    // Backpressure: cell_ready low for 5 cycles while (2,1) = cell 6 is presented
    set_mem(2);
    build_model();
    clear_sched();
    for (int c = 77; c <= 81; c++) ready_lo_at[c] = 1'b1;
    run_scan(400);
    check_timing(6, 5, 99, 0);

    // Mutex stall: 3 blocked cycles during the fetch of interior cell (1,1) = cell 5
    build_model();
    clear_sched();
    for (int c = 58; c <= 60; c++) mutex_at[c] = 1'b1;
    run_scan(400);
    check_timing(99, 0, 5, 3);

    // Reset at cycle 30 of a scan, then a restart with stray start pulses
    clear_sched();
    set_mem(1);
    build_model();
    fin_rel.delete();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 30; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midscan_reset_outputs", 64'({bus.busy, bus.finished, bus.rd_en, bus.rd_x, bus.rd_y,
                                        bus.cell_valid, bus.neighbourhood, bus.cell_x, bus.cell_y}), 64'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("no_finished_after_abort", 64'(fin_rel.size()), 64'd0);
    check("idle_after_abort", 64'(bus.busy), 64'd0);
    build_model();
    start_at[20] = 1'b1;
    start_at[50] = 1'b1;
    run_scan(400);
    check_timing(99, 0, 99, 0);
    clear_sched();

    // Randomized memory, mutex and backpressure
    for (int r = 0; r < 3; r++) begin
      set_mem(2);
      build_model();
      for (int c = 0; c < MAXC; c++) begin
        mutex_at[c]    = ($urandom_range(0, 3) == 0);
        ready_lo_at[c] = ($urandom_range(0, 2) == 0);
      end
      run_scan(MAXC);
      check("rand_hs_count", 64'(hs_rel.size()), 64'(GW * GH));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/iteration_reader.md
# iteration_reader

Reads the current Conway generation from the 1-bit game-grid memory and streams one 3×3 neighbourhood per cell, in raster order, to the rule engine. The rule engine then feeds the iteration writer. It is the read-side counterpart of the iteration path. It shares grid-memory access with the framebuffer side through `framebuffer_mutex`.

## Interface
- `GRID_W`, default 64: grid width in cells, at least 2.
- `GRID_H`, default 48: grid height in cells, at least 2.
- `clk` in 1: the single clock; everything is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: a pulse that begins a full-generation scan; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `finished` out 1: a one-cycle pulse when a scan completes.
- `rd_en` out 1: grid-memory read strobe.
- `rd_x`, `rd_y` out 12: read address, valid while `rd_en` is high.
- `rd_data` in 1: cell state, returned exactly 1 cycle after `rd_en`.
- `framebuffer_mutex` in 1: while high, the reader must not assert `rd_en`.
- `cell_valid` out 1: a neighbourhood is presented on the outputs.
- `cell_ready` in 1: the rule engine accepts the presented neighbourhood.
- `neighbourhood` out 9: bit k = cell (x+dx, y+dy), where k = (dy+1)*3 + (dx+1) and dx, dy ∈ {−1, 0, 1}. Bit 4 is the centre cell.
- `cell_x`, `cell_y` out 12: coordinates of the centre cell.

## Operation
- FSM states are IDLE, FETCH, WAIT, PRESENT and DONE.
- **IDLE:** when `start` = 1, clear the coordinates to (0,0) and the neighbour index k to 0, then go to FETCH.
  - `start` in any other state is ignored.
- **FETCH:** one cycle per neighbour index k = 0..8.
  - If the neighbour lies outside the grid (x+dx < 0, x+dx ≥ GRID_W, y+dy < 0 or y+dy ≥ GRID_H):
    - no read is issued;
    - the bit is forced to 0 (dead border, no wrap-around);
    - k advances even if `framebuffer_mutex` is high.
  - If the neighbour is in the grid and `framebuffer_mutex` = 0:
    - assert `rd_en` with `rd_x`/`rd_y` set to the neighbour coordinates;
    - advance k.
  - If the neighbour is in the grid and `framebuffer_mutex` = 1:
    - `rd_en` = 0 and k holds.
  - `rd_data` is captured into bit k the cycle after any `rd_en`, regardless of the `framebuffer_mutex` level in that cycle.
  - After k = 8 is issued or skipped, go to WAIT.
- **WAIT:** one cycle to capture the final read, then go to PRESENT.
- **PRESENT:** `cell_valid` = 1.
  - `neighbourhood`, `cell_x` and `cell_y` stay stable until `cell_valid` & `cell_ready`.
  - No reads are issued in this state.
  - On handshake at the last cell (GRID_W−1, GRID_H−1), go to DONE.
  - On handshake at any other cell:
    - advance x, wrapping to 0 and incrementing y at GRID_W−1;
    - clear k and the neighbourhood register;
    - go to FETCH.
- **DONE:** `finished` = 1 for one cycle, then go to IDLE.
- Coordinate arithmetic is 12-bit unsigned. Neighbour range checks must not rely on unsigned wrap at coordinate 0.

## Timing
- Reset (asynchronous assertion) puts the FSM in IDLE. All outputs are 0: `busy`, `finished`, `rd_en`, `rd_x`, `rd_y`, `cell_valid`, `neighbourhood`, `cell_x`, `cell_y`.
- Reset mid-scan aborts immediately: no `finished` pulse, and the next `start` begins again at (0,0).
- Cycle numbering: cycle 0 is the edge that samples `start`.
  - Cycles 1–9 are FETCH k = 0..8; cycle 10 is WAIT.
  - `cell_valid` rises at cycle 11.
- With `cell_ready` = 1 and `framebuffer_mutex` = 0, each cell takes exactly 11 cycles.
  - Handshake N (N counted from 0) occurs at cycle 11 + 11N.
  - `finished` is high in the cycle after the last handshake.
- Each cycle `framebuffer_mutex` blocks an in-grid read adds exactly one cycle.
- Each cycle of `cell_ready` = 0 in PRESENT adds exactly one cycle.
- `rd_en` is never high in IDLE, WAIT, PRESENT or DONE, nor in any cycle where `framebuffer_mutex` = 1.

## Test plan
- **Single live cell:** GRID 4×3, memory holds only (1,1) = 1, `cell_ready` = 1.
  - Required: (0,0) gives 9'h100, (1,1) gives 9'h010, (2,2) gives 9'h001, and every other cell that is not adjacent to (1,1) gives 0.
- **All-ones memory, border masking:** GRID 4×3.
  - Required: (0,0) gives 9'h1B0, (3,2) gives 9'h01B, (1,1) gives 9'h1FF.
  - No `rd_en` is issued with an out-of-range address.
- **Full-scan timing:** GRID 4×3, `cell_ready` = 1, `framebuffer_mutex` = 0.
  - Required: 12 handshakes at cycles 11, 22, …, 132, then `finished` at cycle 133 only.
  - Total `rd_en` count is 70, in strict raster order.
- **Backpressure:** hold `cell_ready` low for 5 cycles at cell (2,1).
  - Required: `cell_valid`, `neighbourhood` and `cell_x`/`cell_y` stay stable; `rd_en` = 0; the next cell starts one cycle after the handshake.
- **Mutex stall:** assert `framebuffer_mutex` for 3 cycles during FETCH of interior cell (1,1).
  - Required: `rd_en` is low in those cycles; `cell_valid` arrives 3 cycles late; the neighbourhood is identical to the unstalled run; 9 reads are issued.
- **Reset and restart:** assert `rst_n` = 0 at cycle 30.
  - Required: all outputs are 0 immediately and there is no `finished` pulse.
  - A `start` while busy is ignored, and a new `start` scans from (0,0).
